// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: one-hot hgrant, registered hmaster/hmastlock, locked transfers,
// default master and tenure-limited preemption. AHB_ARB_ROUND_ROBIN_EN selects round-robin winners.
module ahb_bus_arbiter #(
  parameter int MASTER_NUMBER  = 4,
  parameter int DEFAULT_MASTER = MASTER_NUMBER - 1,
  parameter int MAX_TENURE     = 16
) (
  input  logic                     hclk,
  input  logic                     hreset,
  input  logic [MASTER_NUMBER-1:0] hbusreq,
  input  logic [MASTER_NUMBER-1:0] hlock,
  input  logic                     hready,
  output logic [MASTER_NUMBER-1:0] hgrant,
  output logic [3:0]               hmaster,
  output logic                     hmastlock
);

  localparam int              TW          = $clog2(MAX_TENURE + 1);
  localparam logic [TW-1:0]   TENURE_MAX  = TW'(MAX_TENURE);
  localparam logic [3:0]      DEFAULT_IDX = 4'(DEFAULT_MASTER);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DEFAULT = 2'd1,
    ST_OWNED   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  state_t                   state_r, state_nx;
  logic [MASTER_NUMBER-1:0] hgrant_r, grant_nx;
  logic [TW-1:0]            tenure_r, tenure_nx;
  logic [3:0]               hmaster_r, hmaster_nx;
  logic                     hmastlock_r, hmastlock_nx;
  logic                     owner_req_s, owner_lock_s, any_req_s, any_other_s;
  logic [MASTER_NUMBER-1:0] others_s;
  logic [3:0]               win_all_s, win_oth_s;

  function automatic logic [MASTER_NUMBER-1:0] to_onehot(input logic [3:0] idx);
    logic [MASTER_NUMBER-1:0] oh;
    oh = '0;
    for (int j = 0; j < MASTER_NUMBER; j++) begin
      oh[j] = (idx == 4'(j));
    end
    return oh;
  endfunction

  function automatic logic [3:0] to_index(input logic [MASTER_NUMBER-1:0] oh);
    logic [3:0] idx;
    idx = 4'd0;
    for (int j = 0; j < MASTER_NUMBER; j++) begin
      idx = idx | (oh[j] ? 4'(j) : 4'd0);
    end
    return idx;
  endfunction

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic [3:0] last_owner_r;

  // Distance from last_owner+1 (with wrap); the closest requester wins.
  function automatic logic [3:0] pick_rr(input logic [MASTER_NUMBER-1:0] req, input logic [3:0] last);
    logic [3:0] idx;
    int         best;
    int         dist;
    idx  = DEFAULT_IDX;
    best = MASTER_NUMBER;
    for (int j = 0; j < MASTER_NUMBER; j++) begin
      dist = (j + 2 * MASTER_NUMBER - int'(last) - 1) % MASTER_NUMBER;
      if (req[j] && (dist < best)) begin
        best = dist;
        idx  = 4'(j);
      end
    end
    return idx;
  endfunction

  assign win_all_s = pick_rr(hbusreq, last_owner_r);
  assign win_oth_s = pick_rr(others_s, last_owner_r);
`else
  // Scanning downward leaves the lowest requesting index as the winner.
  function automatic logic [3:0] pick_fixed(input logic [MASTER_NUMBER-1:0] req);
    logic [3:0] idx;
    idx = DEFAULT_IDX;
    for (int j = MASTER_NUMBER - 1; j >= 0; j--) begin
      if (req[j]) begin
        idx = 4'(j);
      end
    end
    return idx;
  endfunction

  assign win_all_s = pick_fixed(hbusreq);
  assign win_oth_s = pick_fixed(others_s);
`endif

  // Grant is one-hot, so masking with it isolates the owner's request/lock bits.
  assign owner_req_s  = |(hbusreq & hgrant_r);
  assign owner_lock_s = |(hlock & hgrant_r);
  assign others_s     = hbusreq & ~hgrant_r;
  assign any_req_s    = |hbusreq;
  assign any_other_s  = |others_s;

  // State, grant and tenure registers.
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state_r     <= ST_IDLE;
      hgrant_r    <= '0;
      tenure_r    <= '0;
      hmaster_r   <= 4'd0;
      hmastlock_r <= 1'b0;
    end else begin
      state_r     <= state_nx;
      hgrant_r    <= grant_nx;
      tenure_r    <= tenure_nx;
      hmaster_r   <= hmaster_nx;
      hmastlock_r <= hmastlock_nx;
    end
  end

  // Next-state and grant decision; only hready=1 edges arbitrate.
  always_comb begin
    state_nx = state_r;
    grant_nx = hgrant_r;
    if (hready) begin
      case (state_r)
        ST_IDLE, ST_DEFAULT: begin
          if (any_req_s) begin
            state_nx = ST_OWNED;
            grant_nx = to_onehot(win_all_s);
          end else begin
            state_nx = ST_DEFAULT;
            grant_nx = to_onehot(DEFAULT_IDX);
          end
        end
        ST_OWNED, ST_LOCKED: begin
          // A held lock freezes the grant even if the owner's request drops.
          if (owner_lock_s && (owner_req_s || (state_r == ST_LOCKED))) begin
            state_nx = ST_LOCKED;
          end else if (!owner_req_s) begin
            if (any_req_s) begin
              state_nx = ST_OWNED;
              grant_nx = to_onehot(win_all_s);
            end else begin
              state_nx = ST_DEFAULT;
              grant_nx = to_onehot(DEFAULT_IDX);
            end
          end else if ((tenure_r == TENURE_MAX) && any_other_s) begin
            state_nx = ST_OWNED;
            grant_nx = to_onehot(win_oth_s);
          end else begin
            state_nx = ST_OWNED;
          end
        end
        default: begin
          state_nx = ST_IDLE;
          grant_nx = '0;
        end
      endcase
    end else begin
      state_nx = state_r;
    end

    if (grant_nx != hgrant_r) begin
      tenure_nx = '0;
    end else if (hready && (state_r == ST_OWNED) && (tenure_r != TENURE_MAX)) begin
      tenure_nx = tenure_r + TW'(1);
    end else begin
      tenure_nx = tenure_r;
    end
  end

  // hmaster follows the pre-edge grant on hready beats; hmastlock follows the owner's hlock.
  always_comb begin
    if (hready) begin
      hmaster_nx = to_index(hgrant_r);
    end else begin
      hmaster_nx = hmaster_r;
    end
    hmastlock_nx = owner_lock_s;
  end

`ifdef AHB_ARB_ROUND_ROBIN_EN
  // Round-robin pointer tracks the most recent non-default grant.
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      last_owner_r <= DEFAULT_IDX;
    end else if (state_nx == ST_OWNED) begin
      last_owner_r <= to_index(grant_nx);
    end else begin
      last_owner_r <= last_owner_r;
    end
  end
`endif

  assign hgrant    = hgrant_r;
  assign hmaster   = hmaster_r;
  assign hmastlock = hmastlock_r;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: expected grant/hmaster/hmastlock queued per driven cycle.
module tb_ahb_bus_arbiter;

  localparam int N = 4;

  logic         hclk;
  logic         hreset;
  logic         hready;
  logic [N-1:0] hbusreq;
  logic [N-1:0] hlock;
  logic [N-1:0] hgrant;
  logic [3:0]   hmaster;
  logic         hmastlock;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [3:0]   master;
    logic         lock;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  ahb_bus_arbiter #(
    .MASTER_NUMBER (N),
    .DEFAULT_MASTER(N - 1),
    .MAX_TENURE    (16)
  ) dut (
    .hclk     (hclk),
    .hreset   (hreset),
    .hbusreq  (hbusreq),
    .hlock    (hlock),
    .hready   (hready),
    .hgrant   (hgrant),
    .hmaster  (hmaster),
    .hmastlock(hmastlock)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic apply_reset();
    hreset  = 1'b0;
    hbusreq = 4'b0000;
    hlock   = 4'b0000;
    hready  = 1'b1;
    tick();
    tick();
    hreset = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    hreset  = 1'b0;
    hbusreq = 4'b0000;
    hlock   = 4'b0000;
    hready  = 1'b1;
    tick();
    checks++;
    if ({hgrant, hmaster, hmastlock} !== 9'b0) begin
      errors++;
      $display("FAIL reset_values: got grant=%b master=%0d lock=%b, want all zero", hgrant, hmaster, hmastlock);
    end
    hreset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      sb_q.push_back('{grant: 4'b1000, master: (k == 1) ? 4'd0 : 4'd3, lock: 1'b0});
      tick();
      e = sb_q.pop_front();
      checks++;
      if (hgrant !== e.grant || hmaster !== e.master || hmastlock !== e.lock) begin
        errors++;
        $display("FAIL default_master[%0d]: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                 k, hgrant, hmaster, hmastlock, e.grant, e.master, e.lock);
      end
    end
  endtask

  task automatic test_fixed_priority();
    exp_t       e;
    logic [3:0] req_t [4] = '{4'b0110, 4'b0110, 4'b0100, 4'b0100};
    logic [3:0] gnt_t [4] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100};
    logic [3:0] mst_t [4] = '{4'd3, 4'd1, 4'd1, 4'd2};
    for (int k = 0; k < 4; k++) begin
      hbusreq = req_t[k];
      sb_q.push_back('{grant: gnt_t[k], master: mst_t[k], lock: 1'b0});
      tick();
      e = sb_q.pop_front();
      checks++;
      if (hgrant !== e.grant || hmaster !== e.master || hmastlock !== e.lock) begin
        errors++;
        $display("FAIL fixed_priority[%0d]: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                 k, hgrant, hmaster, hmastlock, e.grant, e.master, e.lock);
      end
    end
  endtask

  task automatic test_lock();
    exp_t e;
    apply_reset();
    hbusreq = 4'b0100;
    hlock   = 4'b0100;
    for (int k = 0; k < 45; k++) begin
      if (k < 2) begin
        hready = 1'b1;
        sb_q.push_back('{grant: 4'b0100, master: (k == 0) ? 4'd0 : 4'd2, lock: (k == 0) ? 1'b0 : 1'b1});
      end else if (k < 42) begin
        hbusreq = 4'b0101;
        hready  = 1'($urandom_range(0, 1));
        sb_q.push_back('{grant: 4'b0100, master: 4'd2, lock: 1'b1});
      end else if (k == 42) begin
        hready = 1'b1;
        hlock  = 4'b0000;
        sb_q.push_back('{grant: 4'b0100, master: 4'd2, lock: 1'b0});
      end else begin
        hbusreq = 4'b0001;
        sb_q.push_back('{grant: 4'b0001, master: (k == 43) ? 4'd2 : 4'd0, lock: 1'b0});
      end
      tick();
      e = sb_q.pop_front();
      checks++;
      if (hgrant !== e.grant || hmaster !== e.master || hmastlock !== e.lock) begin
        errors++;
        $display("FAIL locked_transfer[%0d]: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                 k, hgrant, hmaster, hmastlock, e.grant, e.master, e.lock);
      end
    end
  endtask

  task automatic test_tenure();
    exp_t       e;
    logic [3:0] g;
    logic [3:0] m;
    apply_reset();
    hbusreq = 4'b1000;
    for (int k = 1; k <= 36; k++) begin
      if (k >= 2) hbusreq = 4'b1001;
      g = (k <= 17) ? 4'b1000 : ((k <= 34) ? 4'b0001 : 4'b1000);
      m = (k == 1) ? 4'd0 : ((k <= 18) ? 4'd3 : ((k <= 35) ? 4'd0 : 4'd3));
      sb_q.push_back('{grant: g, master: m, lock: 1'b0});
      tick();
      e = sb_q.pop_front();
      checks++;
      if (hgrant !== e.grant || hmaster !== e.master || hmastlock !== e.lock) begin
        errors++;
        $display("FAIL tenure_preempt[%0d]: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                 k, hgrant, hmaster, hmastlock, e.grant, e.master, e.lock);
      end
    end
  endtask

  task automatic test_wait_states();
    exp_t       e;
    logic [3:0] req_t [9] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0011, 4'b0110, 4'b0110, 4'b0110};
    logic       rdy_t [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] gnt_t [9] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b0010};
    logic [3:0] mst_t [9] = '{4'd0, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd1};
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      hbusreq = req_t[k];
      hready  = rdy_t[k];
      sb_q.push_back('{grant: gnt_t[k], master: mst_t[k], lock: 1'b0});
      tick();
      e = sb_q.pop_front();
      checks++;
      if (hgrant !== e.grant || hmaster !== e.master || hmastlock !== e.lock) begin
        errors++;
        $display("FAIL wait_states[%0d]: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                 k, hgrant, hmaster, hmastlock, e.grant, e.master, e.lock);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    apply_reset();
    hbusreq = 4'b0010;
    hlock   = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        #2;
        hreset = 1'b0;
        #1;
        checks++;
        if ({hgrant, hmaster, hmastlock} !== 9'b0) begin
          errors++;
          $display("FAIL async_reset: got grant=%b master=%0d lock=%b, want all zero", hgrant, hmaster, hmastlock);
        end
        tick();
        hreset  = 1'b1;
        hbusreq = 4'b0001;
        hlock   = 4'b0000;
      end
      if (k < 2) begin
        sb_q.push_back('{grant: 4'b0010, master: (k == 0) ? 4'd0 : 4'd1, lock: (k == 0) ? 1'b0 : 1'b1});
      end else begin
        sb_q.push_back('{grant: 4'b0001, master: 4'd0, lock: 1'b0});
      end
      tick();
      e = sb_q.pop_front();
      checks++;
      if (hgrant !== e.grant || hmaster !== e.master || hmastlock !== e.lock) begin
        errors++;
        $display("FAIL reset_mid_burst[%0d]: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                 k, hgrant, hmaster, hmastlock, e.grant, e.master, e.lock);
      end
    end
  endtask

`ifdef AHB_ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    exp_t       e;
    logic [3:0] req_t [5] = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] gnt_t [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] mst_t [5] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      hbusreq = req_t[k];
      sb_q.push_back('{grant: gnt_t[k], master: mst_t[k], lock: 1'b0});
      tick();
      e = sb_q.pop_front();
      checks++;
      if (hgrant !== e.grant || hmaster !== e.master || hmastlock !== e.lock) begin
        errors++;
        $display("FAIL round_robin[%0d]: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                 k, hgrant, hmaster, hmastlock, e.grant, e.master, e.lock);
      end
    end
  endtask
`endif

  initial begin
    hreset  = 1'b0;
    hbusreq = 4'b0000;
    hlock   = 4'b0000;
    hready  = 1'b1;
    test_reset();
    test_fixed_priority();
    test_lock();
    test_tenure();
    test_wait_states();
    test_reset_mid();
`ifdef AHB_ARB_ROUND_ROBIN_EN
    test_round_robin();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
